fb_fetch_scheduler: RTL and testbench

Sequences framebuffer reads for the display pipeline and shares the single-port framebuffer RAM between display fetch and CPU pixel writes. It prefetches 8-bit color indices into a small FIFO and hands one index per pixel request to the palette/pixel-printer stage. The block sits between the framebuffer RAM, the CPU write path and the pixel printer, all in the vgaClk domain.

---
 rtl/fb_fetch_scheduler.sv | 88 ++++++++
 tb/tb_fb_fetch_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_fetch_scheduler.sv
// fb_fetch_scheduler: shares the framebuffer port between display prefetch and CPU writes,
// and feeds one prefetched color index per pixel request to the pixel printer.
module fb_fetch_scheduler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WATER   = 2,
  parameter int MAX_ADDRESS = 307200,
  parameter int ADDR_W      = 19
) (
  input  logic              vgaClk,
  input  logic              rst,
  input  logic              frameStart,
  input  logic              pixelReq,
  output logic [7:0]        color_index,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDRESS - 1);
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic inflight_q;
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic [PW+1:0] occ;
  logic [7:0] color_q;
  logic uf_q;
  logic elig, fetch, write, push, pop;
  always_comb begin
    occ = {1'b0, cnt_q} + (PW+2)'(inflight_q);
    elig = !rst && !frameStart && state_q == FETCH && occ < (PW+2)'(FIFO_DEPTH);
    fetch = elig && (occ < (PW+2)'(LOW_WATER) || !cpu_req);
    write = !rst && cpu_req && !fetch;
    push = inflight_q && !frameStart;
    pop = pixelReq && !frameStart && cnt_q != '0;
    state_d = frameStart ? FETCH : (fetch && ptr_q == LAST) ? DONE : state_q;
  end
  assign mem_rd      = fetch;
  assign mem_we      = write;
  assign cpu_ack     = write;
  assign mem_addr    = write ? cpu_addr : fetch ? ptr_q : '0;
  assign mem_wdata   = write ? cpu_wdata : 8'h00;
  assign color_index = color_q;
  assign underflow   = uf_q;
  always_ff @(posedge vgaClk) begin
    if (!rst && push) fifo_q[wp_q] <= mem_rdata;
  end
  always_ff @(posedge vgaClk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      color_q    <= 8'h00;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fetch;
      uf_q       <= pixelReq && !frameStart && cnt_q == '0;
      if (frameStart) begin
        ptr_q   <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        cnt_q   <= '0;
        color_q <= 8'h00;
      end else begin
        if (fetch) ptr_q <= ptr_q + 1'b1;
        if (push) wp_q <= wp_q + 1'b1;
        if (pop) rp_q <= rp_q + 1'b1;
        if (pixelReq) color_q <= pop ? fifo_q[rp_q] : 8'h00;
        cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fb_fetch_scheduler.sv
// tb_fb_fetch_scheduler: randomized bench; a queue-based frame model predicts every output each cycle.
module tb_fb_fetch_scheduler;
  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int LW     = 2;
  localparam int MAX    = 1000;
  logic vgaClk = 1'b0, rst = 1'b1, frameStart = 1'b0, pixelReq = 1'b0, cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = 8'h00, mem_rdata = 8'h00;
  logic [7:0] color_index, mem_wdata;
  logic underflow, cpu_ack, mem_rd, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  int cmp = 0, bad = 0, cyc = 0;
  logic acked = 1'b0;
  fb_fetch_scheduler #(.FIFO_DEPTH(DEPTH), .LOW_WATER(LW), .MAX_ADDRESS(MAX), .ADDR_W(ADDR_W)) dut (
    .vgaClk(vgaClk), .rst(rst), .frameStart(frameStart), .pixelReq(pixelReq),
    .color_index(color_index), .underflow(underflow), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  always #5 vgaClk = ~vgaClk;
  logic [ADDR_W+19:0] obs, exp_vec;
  assign obs = {mem_rd, mem_we, cpu_ack, mem_addr, mem_wdata, color_index, underflow};
  // Framebuffer as seen by the DUT: unwritten pixels read back as their low address byte.
  logic [7:0] eram [int];
  always @(posedge vgaClk) begin
    if (mem_we) eram[int'(mem_addr)] = mem_wdata;
    if (mem_rd) mem_rdata <= eram.exists(int'(mem_addr)) ? eram[int'(mem_addr)] : mem_addr[7:0];
    else mem_rdata <= 8'($urandom);
  end
  // Reference: frame-ordered queue of fetched pixels plus one pending read.
  logic [7:0] mram [int];
  logic [7:0] q [$];
  logic [7:0] pend_val = 8'h00, m_color = 8'h00;
  logic pend_v = 1'b0, active = 1'b0, m_uf = 1'b0, e_rd = 1'b0, e_we = 1'b0;
  int nxt = 0, occ = 0;
  always @(negedge vgaClk) begin
    occ = q.size() + int'(pend_v);
    e_rd = !rst && !frameStart && active && occ < DEPTH && (occ < LW || !cpu_req);
    e_we = !rst && cpu_req && !e_rd;
    exp_vec = {e_rd, e_we, e_we, e_we ? cpu_addr : e_rd ? ADDR_W'(nxt) : '0,
               e_we ? cpu_wdata : 8'h00, m_color, m_uf};
  end
  always @(posedge vgaClk) begin
    if (rst) begin
      q.delete(); pend_v = 1'b0; nxt = 0; active = 1'b0; m_color = 8'h00; m_uf = 1'b0;
    end else begin
      if (e_we) mram[int'(cpu_addr)] = cpu_wdata;
      if (frameStart) begin
        q.delete(); pend_v = 1'b0; nxt = 0; active = 1'b1; m_color = 8'h00; m_uf = 1'b0;
      end else begin
        m_uf = 1'b0;
        if (pixelReq) begin
          if (q.size() > 0) m_color = q.pop_front();
          else begin m_color = 8'h00; m_uf = 1'b1; end
        end
        if (pend_v) q.push_back(pend_val);
        pend_v = e_rd;
        if (e_rd) begin
          pend_val = mram.exists(nxt) ? mram[nxt] : 8'(nxt);
          nxt++;
          if (nxt == MAX) active = 1'b0;
        end
      end
    end
  end
  task automatic tick(input logic rs, input logic fs, input logic pr, input logic cpu_new);
    @(posedge vgaClk); #1;
    rst = rs; frameStart = fs; pixelReq = pr;
    if (!cpu_req || acked) begin
      cpu_req = cpu_new;
      cpu_addr = ADDR_W'($urandom_range(0, MAX - 1));
      cpu_wdata = 8'($urandom);
    end
    @(negedge vgaClk); #1;
    acked = cpu_ack;
    cyc++;
  endtask
  task automatic test_reset();
    tick(1, 0, 0, 0);
    cmp++; if ({color_index, underflow, cpu_ack, mem_rd, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {color_index, underflow, cpu_ack, mem_rd, mem_we, mem_addr, mem_wdata});
    end
    for (int i = 0; i < 6; i++) begin
      tick(i < 3, 0, i % 2 == 1, i == 2);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  task automatic test_fill();
    int rd_cnt = 0, first_rd = -1;
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL fill_start cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0);
      rd_cnt += int'(mem_rd);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL fill cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
    cmp++; if (rd_cnt !== 8) begin bad++; $display("FAIL fill_count got=%0d want=8", rd_cnt); end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, i < 4, 0);
      if (mem_rd && first_rd < 0) first_rd = int'(mem_addr);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL fill_pop cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
    cmp++; if (first_rd !== 8) begin bad++; $display("FAIL refetch_addr got=%0d want=8", first_rd); end
  endtask
  task automatic test_cpu_arb();
    tick(0, 1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      tick(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL cpu_arb cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  task automatic test_idle_write();
    tick(1, 0, 0, 0);
    @(posedge vgaClk); #1;
    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 19'h4B000; cpu_wdata = 8'h5A;
    @(negedge vgaClk); #1;
    acked = cpu_ack; cyc++;
    cmp++; if ({mem_we, mem_rd, cpu_ack, mem_addr, mem_wdata} !== {3'b101, 19'h4B000, 8'h5A}) begin
      bad++; $display("FAIL idle_write got=%h want=%h", {mem_we, mem_rd, cpu_ack, mem_addr, mem_wdata}, {3'b101, 19'h4B000, 8'h5A});
    end
    cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL idle_write_vec cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL idle_after cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  task automatic test_full_frame();
    int uf_cnt = 0, last_rd = -1, post_rd = 0;
    tick(0, 1, 0, 0);
    for (int i = 0; i < 3 + MAX + 20; i++) begin
      tick(0, 0, i >= 3 && i < 3 + MAX, 0);
      uf_cnt += int'(underflow);
      if (mem_rd) last_rd = int'(mem_addr);
      if (i >= 3 + MAX) post_rd += int'(mem_rd);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL full_frame cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
    cmp++; if (uf_cnt !== 0) begin bad++; $display("FAIL frame_underflow got=%0d want=0", uf_cnt); end
    cmp++; if (last_rd !== MAX - 1) begin bad++; $display("FAIL last_fetch got=%0d want=%0d", last_rd, MAX - 1); end
    cmp++; if (post_rd !== 0) begin bad++; $display("FAIL done_reads got=%0d want=0", post_rd); end
  endtask
  task automatic test_underflow();
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    cmp++; if ({underflow, color_index} !== 9'h100) begin bad++; $display("FAIL underflow_pulse got=%h want=100", {underflow, color_index}); end
    tick(0, 0, 0, 0);
    cmp++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_width got=%b want=0", underflow); end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, i == 4, 0);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL uf_fill cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
    tick(0, 1, 1, 0);
    cmp++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL fs_cancel got=%b want=0", mem_rd); end
    tick(0, 0, 0, 0);
    cmp++; if ({underflow, color_index, mem_rd, mem_addr} !== {10'h001, 19'h0}) begin
      bad++; $display("FAIL fs_restart got=%h want=%h", {underflow, color_index, mem_rd, mem_addr}, {10'h001, 19'h0});
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, i >= 3, 0);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL fs_stale cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  task automatic test_reset_midframe();
    bit hit = 0;
    tick(0, 1, 0, 0);
    for (int i = 0; i < 60 && !hit; i++) begin
      tick(0, 0, 0, 0);
      hit = q.size() == 5 && pend_v;
    end
    cmp++; if (!hit) begin bad++; $display("FAIL midframe_setup got=%0d want=5", q.size()); end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    cmp++; if ({color_index, underflow, cpu_ack, mem_rd, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL midframe_reset got=%h want=0", {color_index, underflow, cpu_ack, mem_rd, mem_we, mem_addr, mem_wdata});
    end
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    cmp++; if (underflow !== 1'b1) begin bad++; $display("FAIL midframe_empty got=%b want=1", underflow); end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL midframe_idle cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 999) == 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      cmp++; if (obs !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_cpu_arb();
    test_idle_write();
    test_full_frame();
    test_underflow();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
